// File: rtl/wb_cmd_initiator.sv
// Wishbone B4 classic single-transfer initiator driven by a valid/ready command port.
// Define WB_CMD_INITIATOR_ERR_EN to add the wbm_err_i port and bus-error responses.
module wb_cmd_initiator #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic [1:0]      rsp_status_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i
`ifdef WB_CMD_INITIATOR_ERR_EN
  ,
  input  logic            wbm_err_i
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;
  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BUSERR  = 2'b10
  } status_e;

  // A zero-width counter is illegal, so the no-timeout build keeps one idle bit.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  state_e          state_q;
  logic            cmd_ready_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_dat_q;
  status_e         rsp_status_q;
  logic            cyc_q;
  logic            stb_q;
  logic            we_q;
  logic [DW/8-1:0] sel_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            to_hit;
  logic            bus_err;

`ifdef WB_CMD_INITIATOR_ERR_EN
  assign bus_err = wbm_err_i;
`else
  assign bus_err = 1'b0;
`endif

  // The counter holds still when timeouts are disabled, so it can never wrap.
  assign cnt_d  = (TIMEOUT_CYCLES == 0) ? cnt_q : cnt_q + 1'b1;
  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == TO_MAX);

  // NOTE: every register here is state, so all assignments are non-blocking (<=);
  // the async reset branch clears the bus strobes without waiting for a clock edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            we_q        <= cmd_we_i;
            adr_q       <= cmd_adr_i;
            dat_q       <= cmd_dat_i;
            sel_q       <= cmd_sel_i;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_BUS;
          end
        end
        S_BUS: begin
          // Priority: ACK over ERR over timeout.
          if (wbm_ack_i || bus_err || to_hit) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
            if (wbm_ack_i) begin
              rsp_status_q <= ST_OK;
              rsp_dat_q    <= we_q ? '0 : wbm_dat_i;
            end else begin
              rsp_status_q <= bus_err ? ST_BUSERR : ST_TIMEOUT;
              rsp_dat_q    <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = stb_q;
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator (TIMEOUT_CYCLES=4); bus-error cases run only when
// WB_CMD_INITIATOR_ERR_EN is defined.
module tb_wb_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
`ifdef WB_CMD_INITIATOR_ERR_EN
  logic        err;
`endif

  int total = 0;
  int bad   = 0;
  int n     = 0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_status_o(rsp_status),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (wdat),
    .wbm_dat_i   (rdat),
    .wbm_ack_i   (ack)
`ifdef WB_CMD_INITIATOR_ERR_EN
    ,
    .wbm_err_i   (err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    tick();
    // Junk on the command port while busy must not disturb the bus cycle.
    cmd_valid = 1'b0; cmd_we = ~w; cmd_adr = 32'hFFFF_FFFF; cmd_dat = 32'h0; cmd_sel = 4'h0;
    check("cmd_ready_busy", cmd_ready, 0);
  endtask

  // Plays the responder until CYC drops; returns the number of STB cycles seen.
  task automatic run_bus(input int ack_at, input int err_at, input logic [31:0] rd,
                         input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int cnt);
    cnt = 0;
    for (int i = 0; i < 40 && cyc; i++) begin
      cnt++;
      check("stb_high", stb, 1);
      check("adr_stable", adr, a);
      check("we_stable", we, w);
      check("dat_stable", wdat, d);
      check("sel_stable", sel, s);
      check("rsp_idle_in_bus", rsp_valid, 0);
      if (cnt == ack_at) begin ack = 1'b1; rdat = rd; end
`ifdef WB_CMD_INITIATOR_ERR_EN
      if (cnt == err_at) err = 1'b1;
`endif
      tick();
      ack = 1'b0; rdat = 32'hA5A5_A5A5;
`ifdef WB_CMD_INITIATOR_ERR_EN
      err = 1'b0;
`endif
    end
    if (err_at < 0) check("err_at_unused", 0, 1);
    check("bus_ended", cyc, 0);
    check("stb_low_after", stb, 0);
  endtask

  task automatic consume(input logic [31:0] d, input logic [1:0] st);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_dat", rsp_dat, d);
    check("rsp_status", rsp_status, st);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_done", rsp_valid, 0);
    check("cmd_ready_again", cmd_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack = 1'b0; rdat = 32'hA5A5_A5A5;
`ifdef WB_CMD_INITIATOR_ERR_EN
    err = 1'b0;
`endif
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_adr", adr, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write, ACK in the first STB cycle: response two cycles after acceptance.
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    run_bus(1, 0, 32'h0, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, n);
    check("wr_stb_cycles", n, 1);
    check("adr_held", adr, 32'h3000_0004);
    check("we_held", we, 1);
    consume(32'h0, 2'b00);

    // Read, 3 wait states (ACK lands on the timeout-match cycle, ACK wins).
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    run_bus(4, 0, 32'h1234_5678, 1'b0, 32'h3000_0008, 32'h0, 4'hF, n);
    check("rd_stb_cycles", n, 4);
    consume(32'h1234_5678, 2'b00);

    // Read, 1 wait state, partial byte select.
    issue(1'b0, 32'h3000_000C, 32'h5555_0000, 4'h3);
    run_bus(2, 0, 32'hCAFE_F00D, 1'b0, 32'h3000_000C, 32'h5555_0000, 4'h3, n);
    check("rd2_stb_cycles", n, 2);
    consume(32'hCAFE_F00D, 2'b00);

    // Timeout: no ACK, STB high exactly 4 cycles.
    issue(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    run_bus(0, 0, 32'h0, 1'b0, 32'h3000_0040, 32'h0, 4'hF, n);
    check("to_stb_cycles", n, 4);
    consume(32'h0, 2'b01);

    // Backpressure: response held 5 cycles while a new command waits.
    issue(1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'hC);
    run_bus(1, 0, 32'h0, 1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'hC, n);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_dat = '0; cmd_sel = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_dat", rsp_dat, 0);
      check("bp_rsp_status", rsp_status, 0);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_no_cyc", cyc, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_rsp_done", rsp_valid, 0);
    check("bp_cmd_ready", cmd_ready, 1);
    check("bp_no_cyc_yet", cyc, 0);
    tick();
    cmd_valid = 1'b0;
    check("bp_next_cyc", cyc, 1);
    check("bp_next_adr", adr, 32'h3000_0020);
    run_bus(1, 0, 32'h7777_8888, 1'b0, 32'h3000_0020, 32'h0, 4'hF, n);
    consume(32'h7777_8888, 2'b00);

`ifdef WB_CMD_INITIATOR_ERR_EN
    // ERR in the 2nd STB cycle.
    issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
    run_bus(0, 2, 32'h0, 1'b0, 32'h3000_0050, 32'h0, 4'hF, n);
    check("err_stb_cycles", n, 2);
    consume(32'h0, 2'b10);
    // ACK and ERR together: ACK wins.
    issue(1'b0, 32'h3000_0054, 32'h0, 4'hF);
    run_bus(1, 1, 32'h0F0F_0F0F, 1'b0, 32'h3000_0054, 32'h0, 4'hF, n);
    consume(32'h0F0F_0F0F, 2'b00);
`endif

    // Reset during the 2nd wait state.
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    tick();
    check("mid_stb_before_rst", stb, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", cyc, 0);
    check("mid_rst_stb", stb, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_cyc", cyc, 0);
    issue(1'b1, 32'h3000_0060, 32'h1122_3344, 4'h1);
    run_bus(1, 0, 32'h0, 1'b1, 32'h3000_0060, 32'h1122_3344, 4'h1, n);
    consume(32'h0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
